alu_rr_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_core.sv | 30 +++
 rtl/alu_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_rr_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU arbiter: opcodes and FSM state encoding.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MOD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational W-bit add/sub/mul/mod datapath; all results wrap modulo 2^W.
module alu_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [1:0]   i_op,
  output logic [W-1:0] o_result,
  output logic         o_div_zero
);
  import alu_pkg::*;

  logic w_b_zero;

  assign w_b_zero   = (i_b == '0);
  assign o_div_zero = (i_op == OP_MOD) && w_b_zero;

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_MUL:  o_result = i_a * i_b;
      // Guard the divider so a zero divisor yields 0 rather than X
      OP_MOD:  o_result = w_b_zero ? '0 : (i_a % i_b);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one alu_core among NREQ requesters; IDLE/EXEC/RESP sequencing.
module alu_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   a_flat,
  input  logic [NREQ*W-1:0]   b_flat,
  input  logic [2*NREQ-1:0]   op_flat,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [W-1:0]        Out,
  output logic                err,
  output logic                busy
);
  import alu_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          r_state;
  state_t          w_state_next;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [W-1:0]    r_out;
  logic            r_err;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [1:0]      r_op;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_ptr_next;
  logic [W-1:0]    w_result;
  logic            w_div_zero;

  // First asserted request at or after ptr, wrapping modulo NREQ; MSB flags a hit.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] req_v,
                                          input logic [IW-1:0]   ptr);
    logic          found;
    logic [IW-1:0] idx;
    int            k;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!found && req_v[IW'(k)]) begin
        found = 1'b1;
        idx   = IW'(k);
      end
    end
    return {found, idx};
  endfunction

  assign {w_found, w_win} = rr_pick(req, r_ptr);
  assign w_ptr_next = (w_win == IW'(NREQ - 1)) ? '0 : w_win + IW'(1);

  alu_core #(.W(W)) u_alu_core (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_op       (r_op),
    .o_result   (w_result),
    .o_div_zero (w_div_zero)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_state_next = ST_EXEC;
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= '0;
      r_done  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt[w_win] <= 1'b1;
            r_a          <= a_flat[w_win*W +: W];
            r_b          <= b_flat[w_win*W +: W];
            r_op         <= op_flat[w_win*2 +: 2];
            r_owner      <= w_win;
            r_ptr        <= w_ptr_next;
          end
        end
        ST_EXEC: begin
          r_out           <= w_result;
          r_err           <= w_div_zero;
          r_done[r_owner] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign Out  = r_out;
  assign err  = r_err;
  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a grant-driven scoreboard checked on each done pulse.
module tb_alu_rr_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   a_flat;
  logic [NREQ*W-1:0]   b_flat;
  logic [2*NREQ-1:0]   op_flat;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic [W-1:0]        Out;
  logic                err;
  logic                busy;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a_flat  (a_flat),
    .b_flat  (b_flat),
    .op_flat (op_flat),
    .gnt     (gnt),
    .done    (done),
    .Out     (Out),
    .err     (err),
    .busy    (busy)
  );

  typedef struct {
    int         idx;
    logic [W-1:0] out;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   gnt_cyc[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_gnt = -1;
  logic [W-1:0] last_out = '0;
  logic         last_err = 1'b0;

  // Reference arithmetic: {err, result}
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [1:0] op);
    int r;
    case (op)
      2'd0: r = int'(a) + int'(b);
      2'd1: r = int'(a) - int'(b) + (1 << W);
      2'd2: r = int'(a) * int'(b);
      default: begin
        if (b == 0) return {1'b1, {W{1'b0}}};
        r = int'(a) % int'(b);
      end
    endcase
    return {1'b0, W'(r % (1 << W))};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op);
    a_flat[idx*W +: W] = a;
    b_flat[idx*W +: W] = b;
    op_flat[idx*2 +: 2] = op;
  endtask

  // One cycle: sample at negedge, push expectations on grant, pop on done.
  task automatic tick();
    exp_t         e;
    logic [W:0]   m;
    int           k;
    @(negedge clk);
    cyc++;
    if (gnt != 0) begin
      k = 0;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) k = i;
      check("gnt_onehot", $countones(gnt), 1);
      check("busy_exec", busy, 1);
      m = model(a_flat[k*W +: W], b_flat[k*W +: W], op_flat[k*2 +: 2]);
      e.idx = k; e.out = m[W-1:0]; e.err = m[W]; e.cyc = cyc + 1;
      sb.push_back(e);
      gnt_log.push_back(k);
      gnt_cyc.push_back(cyc);
      last_gnt = k;
    end
    if (done != 0) begin
      if (sb.size() == 0) begin
        check("done_unexpected", done, 0);
      end else begin
        e = sb.pop_front();
        check("done_idx", done, 32'(1 << e.idx));
        check("out", Out, e.out);
        check("err", err, e.err);
        check("done_cycle", cyc, e.cyc);
        check("busy_resp", busy, 1);
        last_out = Out;
        last_err = err;
        $display("txn idx=%0d out=%0d err=%0b cyc=%0d", e.idx, Out, err, cyc);
      end
    end
  endtask

  task automatic wait_grants(input int n);
    int start;
    start = gnt_log.size();
    for (int i = 0; i < 40 && (gnt_log.size() - start) < n; i++) tick();
    check("gnt_timeout", gnt_log.size() - start, n);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    check("drain", sb.size(), 0);
  endtask

  task automatic run_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op);
    set_op(idx, a, b, op);
    req[idx] = 1'b1;
    wait_grants(1);
    check("gnt_idx", last_gnt, idx);
    req[idx] = 1'b0;
    drain();
  endtask

  initial begin
    logic [W-1:0] exp_out [4];
    exp_out[0] = 4'd11; exp_out[1] = 4'd13; exp_out[2] = 4'd4; exp_out[3] = 4'd12;

    rst_n = 1'b0; req = '0; a_flat = '0; b_flat = '0; op_flat = '0;
    tick(); tick();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_out", Out, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Requester 0 alone, all four opcodes
    for (int op = 0; op < 4; op++) begin
      run_one(0, 4'd12, 4'd15, 2'(op));
      check("req0_out_tbl", last_out, exp_out[op]);
      check("req0_err_tbl", last_err, 0);
    end

    // Mod by zero then a normal mod from the same requester
    run_one(2, 4'd9, 4'd0, 2'b11);
    check("modz_out", last_out, 0);
    check("modz_err", last_err, 1);
    run_one(2, 4'd9, 4'd4, 2'b11);
    check("mod_out", last_out, 1);
    check("mod_err", last_err, 0);

    // Reset in the middle of EXEC: nothing may complete afterwards
    set_op(3, 4'd5, 4'd6, 2'b00);
    req = 4'b1000;
    wait_grants(1);
    check("pre_rst_gnt", last_gnt, 3);
    rst_n = 1'b0;
    req = '0;
    sb.delete();
    tick();
    check("midrst_gnt", gnt, 0);
    check("midrst_done", done, 0);
    check("midrst_out", Out, 0);
    check("midrst_err", err, 0);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_done", done, 0);
    end

    // Round robin with all requesters held
    for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'd3, 2'(i));
    gnt_log.delete();
    gnt_cyc.delete();
    req = 4'b1111;
    wait_grants(5);
    req = '0;
    drain();
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
      check("rr_order", gnt_log[i], i % NREQ);
      if (i > 0) check("rr_spacing", gnt_cyc[i] - gnt_cyc[i-1], 3);
    end
    tick();

    // Pointer skip: after granting 1, only 0 and 1 request
    run_one(1, 4'd2, 4'd2, 2'b10);
    gnt_log.delete();
    req = 4'b0011;
    wait_grants(2);
    req = '0;
    drain();
    if (gnt_log.size() >= 2) begin
      check("skip_first", gnt_log[0], 0);
      check("skip_second", gnt_log[1], 1);
    end else begin
      check("skip_count", gnt_log.size(), 2);
    end
    tick();

    // Operands changing right after the grant must not affect the result
    set_op(1, 4'd7, 4'd5, 2'b00);
    req = 4'b0010;
    wait_grants(1);
    check("stab_gnt", last_gnt, 1);
    req = '0;
    set_op(1, 4'd0, 4'd9, 2'b10);
    drain();
    check("stab_out", last_out, 12);
    check("stab_err", last_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
